sysgen_arb: RTL
===============

SYSGEN_ARB -- requirements
Module: sysgen_arb

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning fixed datapath cycles from driven inputs to valid data_out/data_out1/data_out2 (legal 1..16).
REQ-002 SHALL have parameter RSP_DEPTH, default 8, meaning response FIFO entries (power of two, >= LATENCY).
REQ-003 SHALL have ports: clk input 1, sole clock; all logic rising-edge.
REQ-004 SHALL have ports: resetn input 1, reset asynchronous and active-low.
REQ-005 SHALL have ports: enable input 1, run permission; cfg_prio input 1, 0 = round-robin, 1 = requester 0 fixed priority.
REQ-006 SHALL have ports: reqN_valid input 1, reqN_ready output 1, reqN_a input 16, reqN_b input 16, reqN_op input 4, reqN_mode input 1, for N = 0,1.
REQ-007 SHALL have ports: dp_data_in output 16, dp_data_in2 output 16, dp_data_in1 output 4, dp_data_in3 output 1 (to datapath data_in/data_in2/data_in1/data_in3).
REQ-008 SHALL have ports: dp_data_out input 25, dp_data_out1 input 1, dp_data_out2 input 1 (from datapath).
REQ-009 SHALL have ports: rsp_valid output 1, rsp_ready input 1, rsp_id output 1, rsp_data output 25, rsp_flag1 output 1, rsp_flag2 output 1.
REQ-010 SHALL have ports: busy output 1, state output 2 (IDLE=0, RUN=1, DRAIN=2).

Function
REQ-011 SHALL implement FSM: IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when in-flight=0 and FIFO empty; DRAIN->RUN if enable re-asserts.
REQ-012 SHALL issue at most one request per cycle, only in RUN; a request is accepted on reqN_valid & reqN_ready.
REQ-013 SHALL assert reqN_ready only for the grant winner, and only when inflight + fifo_count < RSP_DEPTH.
REQ-014 SHALL, round-robin mode, grant the requester not granted last when both valid; single valid wins; last-grant pointer resets to 1 (req0 wins first tie).
REQ-015 SHALL, fixed mode, grant req0 whenever req0_valid=1.
REQ-016 SHALL register accepted operands onto dp_* outputs the cycle after acceptance and hold them until the next acceptance.
REQ-017 SHALL track in-flight operations with a LATENCY-deep valid/id shift register; on its tail, capture dp_data_out/1/2 plus id into the FIFO.
REQ-018 SHALL never overflow the FIFO: credit check per REQ-013 covers all in-flight entries.
REQ-019 SHALL present FIFO head on rsp_*; pop on rsp_valid & rsp_ready; simultaneous push and pop keeps count unchanged.
REQ-020 SHALL deliver results in acceptance order; busy = (state != IDLE) or inflight != 0 or FIFO non-empty.
REQ-021 SHALL keep inflight count 0..LATENCY and fifo count 0..RSP_DEPTH without wrap.

Reset
REQ-022 SHALL on resetn=0 immediately clear: state=IDLE, all readys 0, rsp_valid 0, rsp_id/data/flags 0, dp_* outputs 0, busy 0, FIFO empty, in-flight cleared.
REQ-023 SHALL discard in-flight and queued results on reset mid-operation; no response emitted afterwards for them.
REQ-024 SHALL release reset synchronously-deasserted externally; first grant possible the first cycle with resetn=1 and enable=1 after entering RUN.

Structure
REQ-025 SHALL take widths (16, 16, 4, 1, 25) and state encoding from shared package sysgen_pkg.
REQ-026 SHALL instantiate one sub-module sysgen_rsp_fifo (synchronous FIFO, depth RSP_DEPTH, width 28).

Verification
REQ-027 Single op: enable=1, req0 a=0x0010 once, LATENCY=4 -> dp_data_in=0x0010 at accept+1, rsp_valid at accept+LATENCY+1 with id=0, data=model value.
REQ-028 Contention RR: both valid continuously for 6 cycles -> grants 0,1,0,1,0,1; cfg_prio=1 -> six grants to req0.
REQ-029 Backpressure: rsp_ready=0, stream req1 -> exactly 8 acceptances (RSP_DEPTH=8), then ready=0 until one pop.
REQ-030 Drain: drop enable with 3 in flight -> state DRAIN, no new grants, 3 responses, then IDLE, busy=0.
REQ-031 Reset mid-op: resetn=0 with 2 in flight and 2 queued -> all outputs 0 same cycle; no stale responses after release.
REQ-032 Simultaneous push/pop at FIFO full-1 with rsp_ready=1 -> count stable, ordering preserved.

Source files
------------

// File: rtl/sysgen_pkg.sv
// Shared widths, FSM encoding and response record for the sysgen arbiter.
package sysgen_pkg;

  localparam int A_W    = 16;
  localparam int B_W    = 16;
  localparam int OP_W   = 4;
  localparam int MODE_W = 1;
  localparam int DOUT_W = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic              id;
    logic              flag2;
    logic              flag1;
    logic [DOUT_W-1:0] data;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/sysgen_arb_if.sv
// Request, datapath and response signals between the arbiter and its environment.
interface sysgen_arb_if;
  import sysgen_pkg::*;

  logic              enable;
  logic              cfg_prio;
  logic              req0_valid;
  logic              req0_ready;
  logic [A_W-1:0]    req0_a;
  logic [B_W-1:0]    req0_b;
  logic [OP_W-1:0]   req0_op;
  logic [MODE_W-1:0] req0_mode;
  logic              req1_valid;
  logic              req1_ready;
  logic [A_W-1:0]    req1_a;
  logic [B_W-1:0]    req1_b;
  logic [OP_W-1:0]   req1_op;
  logic [MODE_W-1:0] req1_mode;
  logic [A_W-1:0]    dp_data_in;
  logic [B_W-1:0]    dp_data_in2;
  logic [OP_W-1:0]   dp_data_in1;
  logic [MODE_W-1:0] dp_data_in3;
  logic [DOUT_W-1:0] dp_data_out;
  logic              dp_data_out1;
  logic              dp_data_out2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DOUT_W-1:0] rsp_data;
  logic              rsp_flag1;
  logic              rsp_flag2;
  logic              busy;
  logic [1:0]        state;

  modport slave (
    input  enable, cfg_prio,
    input  req0_valid, req0_a, req0_b, req0_op, req0_mode,
    input  req1_valid, req1_a, req1_b, req1_op, req1_mode,
    input  dp_data_out, dp_data_out1, dp_data_out2, rsp_ready,
    output req0_ready, req1_ready,
    output dp_data_in, dp_data_in2, dp_data_in1, dp_data_in3,
    output rsp_valid, rsp_id, rsp_data, rsp_flag1, rsp_flag2, busy, state
  );

  modport master (
    output enable, cfg_prio,
    output req0_valid, req0_a, req0_b, req0_op, req0_mode,
    output req1_valid, req1_a, req1_b, req1_op, req1_mode,
    output dp_data_out, dp_data_out1, dp_data_out2, rsp_ready,
    input  req0_ready, req1_ready,
    input  dp_data_in, dp_data_in2, dp_data_in1, dp_data_in3,
    input  rsp_valid, rsp_id, rsp_data, rsp_flag1, rsp_flag2, busy, state
  );

endinterface

// File: rtl/sysgen_rsp_fifo.sv
// Synchronous response FIFO; head is visible combinationally on o_rdata.
module sysgen_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_push  = i_push & (r_count != CW'(DEPTH));
  assign w_pop   = i_pop & (r_count != '0);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // NOTE: storage is left unreset; occupancy lives in r_count, so stale words are never presented as valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_next(r_wptr);
      if (w_pop)  r_rptr <= ptr_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sysgen_arb.sv
// Two-requester arbiter feeding a fixed-latency datapath; results return in order through a credit-checked FIFO.
module sysgen_arb
  import sysgen_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int RSP_DEPTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  sysgen_arb_if.slave  bus
);

  localparam int IF_W  = $clog2(LATENCY + 1);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  state_e            r_state;
  logic              r_last;
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_id;
  logic [IF_W-1:0]   r_inflight;
  logic [A_W-1:0]    r_dp_a;
  logic [B_W-1:0]    r_dp_b;
  logic [OP_W-1:0]   r_dp_op;
  logic [MODE_W-1:0] r_dp_mode;

  logic              w_run;
  logic              w_credit;
  logic              w_pick0;
  logic              w_pick1;
  logic              w_rdy0;
  logic              w_rdy1;
  logic              w_acc;
  logic              w_tail;
  logic              w_pop;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [SUM_W-1:0]  w_used;
  rsp_t              w_push_data;
  rsp_t              w_head;
  rsp_t              w_rsp;

  // Every accepted op already owns a FIFO slot, whether still in flight or queued.
  assign w_used   = SUM_W'(r_inflight) + SUM_W'(w_fifo_cnt);
  assign w_credit = (w_used < SUM_W'(RSP_DEPTH));
  assign w_run    = (r_state == ST_RUN) & bus.enable;

  // r_last names the requester granted most recently; a tie goes to the other one.
  assign w_pick0 = bus.req0_valid & (bus.cfg_prio | ~bus.req1_valid | r_last);
  assign w_pick1 = bus.req1_valid & ~w_pick0;
  assign w_rdy0  = w_run & w_credit & w_pick0;
  assign w_rdy1  = w_run & w_credit & w_pick1;
  assign w_acc   = w_rdy0 | w_rdy1;
  assign w_tail  = r_vld[LATENCY-1];

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;

  // NOTE: state is written with <= so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.enable) r_state <= ST_RUN;
        ST_RUN:   if (!bus.enable) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (bus.enable)                               r_state <= ST_RUN;
          else if ((r_inflight == '0) && w_fifo_empty)  r_state <= ST_IDLE;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last     <= 1'b1;
      r_dp_a     <= '0;
      r_dp_b     <= '0;
      r_dp_op    <= '0;
      r_dp_mode  <= '0;
      r_vld      <= '0;
      r_id       <= '0;
      r_inflight <= '0;
    end else begin
      if (w_acc) begin
        r_last    <= w_rdy1;
        r_dp_a    <= w_rdy1 ? bus.req1_a    : bus.req0_a;
        r_dp_b    <= w_rdy1 ? bus.req1_b    : bus.req0_b;
        r_dp_op   <= w_rdy1 ? bus.req1_op   : bus.req0_op;
        r_dp_mode <= w_rdy1 ? bus.req1_mode : bus.req0_mode;
      end
      r_vld[0] <= w_acc;
      r_id[0]  <= w_rdy1;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
      case ({w_acc, w_tail})
        2'b10:   r_inflight <= r_inflight + IF_W'(1);
        2'b01:   r_inflight <= r_inflight - IF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.dp_data_in  = r_dp_a;
  assign bus.dp_data_in2 = r_dp_b;
  assign bus.dp_data_in1 = r_dp_op;
  assign bus.dp_data_in3 = r_dp_mode;

  assign w_push_data = '{id:    r_id[LATENCY-1],
                         flag2: bus.dp_data_out2,
                         flag1: bus.dp_data_out1,
                         data:  bus.dp_data_out};

  sysgen_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .i_push  (w_tail),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  // Head is masked while empty so the unreset storage never reaches the outputs.
  assign w_rsp         = w_fifo_empty ? '0 : w_head;
  assign w_pop         = ~w_fifo_empty & bus.rsp_ready;
  assign bus.rsp_valid = ~w_fifo_empty;
  assign bus.rsp_id    = w_rsp.id;
  assign bus.rsp_data  = w_rsp.data;
  assign bus.rsp_flag1 = w_rsp.flag1;
  assign bus.rsp_flag2 = w_rsp.flag2;
  assign bus.busy      = (r_state != ST_IDLE) | (r_inflight != '0) | ~w_fifo_empty;
  assign bus.state     = r_state;

endmodule
